up_count_capture: RTL and testbench

//   Downstream consumer of the free-running 4-bit up-counter. Snapshots the counter

---
 rtl/up_count_capture.sv | 133 +++++++++++++
 tb/tb_up_count_capture.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/up_count_capture.sv
// up_count_capture: snapshots a free-running counter on an event edge into a small FIFO
// with a wrap tag. Define CNT_CAP_SYNC_EN to pass evt_in through a 2-flop synchronizer.
module up_count_capture #(
   parameter int CNT_W = 4,
   parameter int DEPTH = 4,
   parameter int EDGE  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CNT_W-1:0]         cnt_in,
   input  logic                     evt_in,
   input  logic                     cap_ready,
   output logic                     cap_valid,
   output logic [CNT_W-1:0]         cap_data,
   output logic                     cap_wrap,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]        FULL_LVL = (PW+1)'(DEPTH);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   logic              evt_s;
   logic              evt_d;
   logic              armed;
   logic              evt_edge;
   logic [CNT_W-1:0]  cnt_d;
   logic              wrap_now;
   logic              wrap_pend;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     last_ptr;
   logic [PW-1:0]     head_ptr;
   logic              full;
   logic              pop;
   logic              accept;
   logic              drop;
   logic [CNT_W:0]    mem [DEPTH];

`ifdef CNT_CAP_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], evt_in};
      end
   end

   assign evt_s = sync[1];
`else
   assign evt_s = evt_in;
`endif

   // armed blocks a spurious edge from a line that is already active at reset release
   assign evt_edge = armed & ((EDGE != 0) ? (evt_s & ~evt_d) : (~evt_s & evt_d));
   assign wrap_now = (cnt_d == CNT_MAX) & (cnt_in == '0);

   assign full     = (fifo_level == FULL_LVL);
   assign cap_valid = (fifo_level != '0);
   assign pop      = cap_valid & cap_ready;
   assign accept   = evt_edge & (~full | pop);
   assign drop     = evt_edge & full & ~pop;

   // When empty, present the most recently written slot instead of the next write slot
   assign last_ptr = wr_ptr - PW'(1);
   assign head_ptr = cap_valid ? rd_ptr : last_ptr;
   assign cap_data = mem[head_ptr][CNT_W:1];
   assign cap_wrap = mem[head_ptr][0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evt_d <= 1'b0;
         armed <= 1'b0;
         cnt_d <= '0;
      end else begin
         evt_d <= evt_s;
         armed <= 1'b1;
         cnt_d <= cnt_in;
      end
   end

   // A wrap seen in the same cycle as an accepted write travels in that entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_pend <= 1'b0;
      end else if (accept) begin
         wrap_pend <= 1'b0;
      end else if (wrap_now) begin
         wrap_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         fifo_level <= fifo_level + (PW+1)'(accept) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (accept) begin
         mem[wr_ptr] <= {cnt_in, wrap_pend | wrap_now};
      end
   end

endmodule

// File: tb/tb_up_count_capture.sv
// Randomized bench for up_count_capture: a rising-edge and a falling-edge instance share
// stimulus and are checked every cycle against a queue-level reference model.
module tb_up_count_capture;

   localparam int CNT_W = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef CNT_CAP_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [CNT_W-1:0] cnt_in = '0;
   logic             evt_in = 1'b1;
   logic             cap_ready = 1'b0;
   logic             ovf_clr = 1'b0;

   logic             valid_r, wrap_r, ovf_r;
   logic [CNT_W-1:0] data_r;
   logic [LW-1:0]    level_r;
   logic             valid_f, wrap_f, ovf_f;
   logic [CNT_W-1:0] data_f;
   logic [LW-1:0]    level_f;

   int n_checks = 0;
   int n_fail   = 0;

   up_count_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .EDGE(1)) u_rise (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .evt_in(evt_in), .cap_ready(cap_ready),
      .cap_valid(valid_r), .cap_data(data_r), .cap_wrap(wrap_r), .fifo_level(level_r),
      .overflow(ovf_r), .ovf_clr(ovf_clr)
   );

   up_count_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .EDGE(0)) u_fall (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .evt_in(evt_in), .cap_ready(cap_ready),
      .cap_valid(valid_f), .cap_data(data_f), .cap_wrap(wrap_f), .fifo_level(level_f),
      .overflow(ovf_f), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO as array + head/count, index 0 = rising, 1 = falling
   logic       hist [4];
   logic       m_armed;
   int         m_cntd;
   logic       m_wpend [2];
   logic [4:0] m_mem [2][DEPTH];
   int         m_head [2];
   int         m_cnt [2];
   logic       m_ovf [2];

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      m_armed = 1'b0;
      m_cntd  = 0;
      for (int k = 0; k < 2; k++) begin
         m_wpend[k] = 1'b0;
         m_head[k]  = 0;
         m_cnt[k]   = 0;
         m_ovf[k]   = 1'b0;
         for (int j = 0; j < DEPTH; j++) m_mem[k][j] = '0;
      end
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      logic ev_now, ev_prev, wrap_now, edge_k, dropped;
      ev_now   = (LAT == 0) ? evt_in : hist[(LAT == 0) ? 0 : LAT - 1];
      ev_prev  = hist[LAT];
      wrap_now = (m_cntd == 15) && (int'(cnt_in) == 0);
      for (int k = 0; k < 2; k++) begin
         edge_k  = m_armed && ((k == 0) ? (ev_now && !ev_prev) : (!ev_now && ev_prev));
         dropped = 1'b0;
         if (m_cnt[k] > 0 && cap_ready) begin
            m_head[k] = (m_head[k] + 1) % DEPTH;
            m_cnt[k]--;
         end
         if (edge_k && m_cnt[k] < DEPTH) begin
            m_mem[k][(m_head[k] + m_cnt[k]) % DEPTH] = {cnt_in, m_wpend[k] | wrap_now};
            m_cnt[k]++;
            m_wpend[k] = 1'b0;
         end else begin
            if (edge_k) dropped = 1'b1;
            if (wrap_now) m_wpend[k] = 1'b1;
         end
         if (ovf_clr) m_ovf[k] = 1'b0;
         if (dropped) m_ovf[k] = 1'b1;
      end
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = evt_in;
      m_cntd  = int'(cnt_in);
      m_armed = 1'b1;
   endtask

   task automatic check_dut(input int k, input string nm, input logic v, input logic [CNT_W-1:0] d,
                            input logic w, input logic [LW-1:0] lvl, input logic o);
      chk({nm, "_valid"}, int'(v), int'(m_cnt[k] > 0));
      chk({nm, "_level"}, int'(lvl), m_cnt[k]);
      chk({nm, "_overflow"}, int'(o), int'(m_ovf[k]));
      if (m_cnt[k] > 0) begin
         chk({nm, "_data"}, int'(d), int'(m_mem[k][m_head[k]][4:1]));
         chk({nm, "_wrap"}, int'(w), int'(m_mem[k][m_head[k]][0]));
      end
   endtask

   task automatic check_reset_state();
      chk("rst_valid_r", int'(valid_r), 0);
      chk("rst_data_r",  int'(data_r), 0);
      chk("rst_wrap_r",  int'(wrap_r), 0);
      chk("rst_level_r", int'(level_r), 0);
      chk("rst_ovf_r",   int'(ovf_r), 0);
      chk("rst_valid_f", int'(valid_f), 0);
      chk("rst_level_f", int'(level_f), 0);
      chk("rst_ovf_f",   int'(ovf_f), 0);
   endtask

   initial begin
      model_reset();
      // Event line held high through reset and release
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc % 1000 == 999) begin
            reset = 1'b0;
            #1;
            check_reset_state();
            model_reset();
            @(negedge clk);
            reset = 1'b1;
         end
         check_dut(0, "rise", valid_r, data_r, wrap_r, level_r, ovf_r);
         check_dut(1, "fall", valid_f, data_f, wrap_f, level_f, ovf_f);
         cnt_in = cnt_in + 1'b1;
         if (cyc < 6) begin
            evt_in    = 1'b1;
            cap_ready = 1'b0;
         end else begin
            if ($urandom_range(2) == 0) evt_in = ~evt_in;
            case ((cyc / 64) % 3)
               0:       cap_ready = ($urandom_range(9) < 8);
               1:       cap_ready = ($urandom_range(9) == 0);
               default: cap_ready = ($urandom_range(1) == 0);
            endcase
         end
         ovf_clr = ($urandom_range(15) == 0);
         model_step();
      end
      @(negedge clk);
      check_dut(0, "rise", valid_r, data_r, wrap_r, level_r, ovf_r);
      check_dut(1, "fall", valid_f, data_f, wrap_f, level_f, ovf_f);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
